// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC channel scanner.
package adc_scan_pkg;
   localparam int CH_W = 5;

   localparam int ERR_CHAN  = 0;
   localparam int ERR_TMO   = 1;
   localparam int ERR_STRAY = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_EMIT
   } state_t;
endpackage

// File: rtl/adc_avg_accum.sv
// Sums 2^AVG_LOG2 samples and registers the truncated mean when the set completes.
module adc_avg_accum #(
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              add,
   input  logic [DATA_W-1:0] sample,
   output logic              done,
   output logic [DATA_W-1:0] avg
);
   localparam int ACC_W   = DATA_W + AVG_LOG2;
   localparam int CNT_W   = AVG_LOG2 + 1;
   localparam int SAMPLES = 1 << AVG_LOG2;

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic [CNT_W-1:0] samp_cnt;

   // done is high while the next add completes the set
   always_comb begin
      sum  = acc + ACC_W'(sample);
      done = (samp_cnt == CNT_W'(SAMPLES - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         samp_cnt <= '0;
         avg      <= '0;
      end else if (clear) begin
         acc      <= '0;
         samp_cnt <= '0;
      end else if (add) begin
         acc      <= sum;
         samp_cnt <= samp_cnt + 1'b1;
         if (done)
            avg <= DATA_W'(sum >> AVG_LOG2);
      end
   end
endmodule

// File: rtl/adc_scan_averager.sv
// Scans a channel range with single-sample ADC commands and streams one averaged
// result per channel; one command is outstanding at a time.
module adc_scan_averager
   import adc_scan_pkg::*;
#(
   parameter int  NUM_CH      = 4,
   parameter int  FIRST_CH    = 1,
   parameter int  DATA_W      = 12,
   parameter int  AVG_LOG2    = 2,
   parameter int  TIMEOUT_CYC = 1024,
   localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   input  logic              stop,
   output logic              busy,
   output logic              scan_done,
   output logic [2:0]        err,
   output logic              cmd_valid,
   output logic [CH_W-1:0]   cmd_channel,
   output logic              cmd_sop,
   output logic              cmd_eop,
   input  logic              cmd_ready,
   input  logic              rsp_valid,
   input  logic [CH_W-1:0]   rsp_channel,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              result_valid,
   output logic [IDX_W-1:0]  result_idx,
   output logic [DATA_W-1:0] result_data,
   input  logic              result_ready
);
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   function automatic logic [CH_W-1:0] chan_of(input logic [IDX_W-1:0] i);
      return CH_W'(FIRST_CH) + CH_W'(i);
   endfunction

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             cont;
   logic             stop_lat;
   logic [TMR_W-1:0] timer;

   logic start_ok, emit_fire, rsp_match, stop_eff, last_idx, timeout_hit;
   logic acc_clear, acc_add, acc_done;

   always_comb begin
      start_ok    = (state == ST_IDLE) && start;
      emit_fire   = (state == ST_EMIT) && result_ready;
      rsp_match   = (rsp_channel == cmd_channel);
      acc_add     = (state == ST_WAIT_RSP) && rsp_valid && rsp_match;
      acc_clear   = start_ok || emit_fire;
      stop_eff    = stop_lat || stop;
      last_idx    = (idx == IDX_W'(NUM_CH - 1));
      timeout_hit = (TIMEOUT_CYC != 0) && (timer == TMR_W'(TIMEOUT_CYC - 1));
   end

   assign cmd_sop = cmd_valid;
   assign cmd_eop = cmd_valid;

   adc_avg_accum #(
      .DATA_W  (DATA_W),
      .AVG_LOG2(AVG_LOG2)
   ) u_accum (
      .clk   (clk),
      .reset (reset),
      .clear (acc_clear),
      .add   (acc_add),
      .sample(rsp_data),
      .done  (acc_done),
      .avg   (result_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         idx          <= '0;
         cont         <= 1'b0;
         stop_lat     <= 1'b0;
         timer        <= '0;
         busy         <= 1'b0;
         scan_done    <= 1'b0;
         err          <= '0;
         cmd_valid    <= 1'b0;
         cmd_channel  <= '0;
         result_valid <= 1'b0;
         result_idx   <= '0;
      end else begin
         scan_done <= 1'b0;
         if (state != ST_IDLE)
            stop_lat <= stop_lat || stop;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  err         <= '0;
                  idx         <= '0;
                  cont        <= continuous;
                  stop_lat    <= 1'b0;
                  busy        <= 1'b1;
                  cmd_valid   <= 1'b1;
                  cmd_channel <= chan_of('0);
                  state       <= ST_ISSUE;
               end
            end

            // valid stays up until accepted, regardless of stop
            ST_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  timer     <= '0;
                  state     <= ST_WAIT_RSP;
               end
            end

            ST_WAIT_RSP: begin
               timer <= timer + 1'b1;
               if (rsp_valid) begin
                  if (rsp_match && acc_done) begin
                     result_valid <= 1'b1;
                     result_idx   <= idx;
                     state        <= ST_EMIT;
                  end else begin
                     if (!rsp_match)
                        err[ERR_CHAN] <= 1'b1;
                     cmd_valid <= 1'b1;
                     state     <= ST_ISSUE;
                  end
               end else if (timeout_hit) begin
                  err[ERR_TMO] <= 1'b1;
                  cmd_valid    <= 1'b1;
                  state        <= ST_ISSUE;
               end
            end

            ST_EMIT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  if (last_idx) begin
                     scan_done <= 1'b1;
                     idx       <= '0;
                     if (cont && !stop_eff) begin
                        cmd_valid   <= 1'b1;
                        cmd_channel <= chan_of('0);
                        state       <= ST_ISSUE;
                     end else begin
                        busy     <= 1'b0;
                        stop_lat <= 1'b0;
                        state    <= ST_IDLE;
                     end
                  end else begin
                     idx <= idx + 1'b1;
                     if (stop_eff) begin
                        busy     <= 1'b0;
                        stop_lat <= 1'b0;
                        state    <= ST_IDLE;
                     end else begin
                        cmd_valid   <= 1'b1;
                        cmd_channel <= chan_of(idx + 1'b1);
                        state       <= ST_ISSUE;
                     end
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase

         // A response is only expected while a command is outstanding
         if (rsp_valid && (state != ST_WAIT_RSP))
            err[ERR_STRAY] <= 1'b1;
      end
   end
endmodule

// File: doc/adc_scan_averager.md
Name: adc_scan_averager

Overview:
Parametrised channel scanner for the modular ADC sequencer streams. Issues single-sample commands over a configurable channel range and accumulates 2^AVG_LOG2 samples per channel. Emits one averaged result per channel on a valid/ready stream and supports single-shot or continuous scans. Sits between the ADC command/response Avalon-ST ports of the system core and the consuming logic (audio/control path).

Parameters:
NUM_CH, 4, channels per scan (1..16)
FIRST_CH, 1, ADC channel number of scan index 0; FIRST_CH+NUM_CH-1 <= 31
DATA_W, 12, ADC sample width
AVG_LOG2, 2, log2 of samples averaged per channel (0..6)
TIMEOUT_CYC, 1024, response timeout in clk cycles; 0 disables

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  pulse: begin scan; ignored while busy
continuous  in  1  sampled at start: 1 = rescan until stopped
stop  in  1  pulse: terminate at next channel boundary
busy  out  1  high from accepted start until return to IDLE
scan_done  out  1  one-cycle pulse after last channel of each scan is emitted
err  out  3  sticky {stray, timeout, chan_mismatch}; cleared on accepted start
cmd_valid  out  1  ADC command valid
cmd_channel  out  5  ADC channel requested
cmd_sop  out  1  equals cmd_valid
cmd_eop  out  1  equals cmd_valid
cmd_ready  in  1  ADC command ready
rsp_valid  in  1  ADC response valid (no backpressure)
rsp_channel  in  5  ADC response channel
rsp_data  in  DATA_W  ADC sample
result_valid  out  1  averaged result valid
result_idx  out  clog2(NUM_CH) (min 1)  scan index 0..NUM_CH-1
result_data  out  DATA_W  average
result_ready  in  1  consumer ready

Behaviour:
- Reset (async): state IDLE; all outputs 0; accumulator, counters, idx, stop latch, err cleared.
- States: IDLE, ISSUE, WAIT_RSP, EMIT.
- IDLE: start -> clear err, idx=0, acc=0, samp_cnt=0, latch continuous -> ISSUE. busy=1 from next cycle.
- ISSUE: cmd_valid=1, cmd_channel=FIRST_CH+idx. Held stable until cmd_ready (valid never dropped, even on stop). Handshake -> WAIT_RSP with timer=0.
- Only one command outstanding, so responses are never lost.
- WAIT_RSP: on rsp_valid with rsp_channel==FIRST_CH+idx: acc+=rsp_data and samp_cnt+=1. If samp_cnt reaches 2^AVG_LOG2 -> EMIT, else -> ISSUE.
- WAIT_RSP, channel mismatch: set err[0], discard the sample, -> ISSUE (reissue).
- WAIT_RSP, timer reaches TIMEOUT_CYC: set err[1], -> ISSUE (reissue). A late response to a timed-out command arriving during ISSUE counts as stray.
- Accumulator width DATA_W+AVG_LOG2, no overflow possible.
- result_data = acc >> AVG_LOG2 (truncating), registered.
- result_valid rises the cycle after the final sample's rsp_valid.
- EMIT: result_valid/idx/data held stable until result_ready. On handshake: acc=0, samp_cnt=0.
  - If idx==NUM_CH-1: pulse scan_done, idx=0. Then -> ISSUE if continuous and no stop latched, else IDLE.
  - Otherwise idx+=1 -> ISSUE, unless stop is latched -> IDLE.
- stop latched any cycle while busy; cleared on entering IDLE. stop in IDLE is ignored.
- rsp_valid in IDLE, ISSUE or EMIT: set err[2], data ignored.
- start while busy: ignored.
- Simultaneous stop and final-channel EMIT handshake: go IDLE, scan_done still pulses.
- The scanner stalls indefinitely under result backpressure; no samples are dropped.

Decomposition:
- Package adc_scan_pkg: state enum, err bit index constants (ERR_CHAN=0, ERR_TMO=1, ERR_STRAY=2), ADC channel width constant 5.
- One sub-module: adc_avg_accum (acc, samp_cnt, done flag, shifted average output).

Test Plan:
- NUM_CH=3, FIRST_CH=1, AVG_LOG2=2, single-shot; responses 100,101,102,103 per channel -> three results idx 0,1,2, data 101 each; cmd_channel sequence 1×4, 2×4, 3×4; scan_done once; busy falls after.
- cmd_ready low for 5 cycles -> cmd_valid and cmd_channel stable throughout; one command accepted; no extra responses counted.
- result_ready low for 10 cycles in EMIT -> result held stable; no cmd_valid asserted; resumes at next idx after ready.
- TIMEOUT_CYC=16, response withheld -> err=3'b010 after 16 cycles, same channel reissued; later correct samples average correctly.
- Response channel 7 while channel 2 expected -> err[0] set, sample excluded, reissue of channel 2; average is unaffected.
- Continuous mode, stop pulsed mid-channel 1 -> finishes channel 1 emit, returns to IDLE, no channel 2 command. Reset asserted during WAIT_RSP -> all outputs 0 immediately, next start clean.
